// File: rtl/mpmc11_chan_sched_fta.sv
// mpmc11_chan_sched_fta
// ---------------------------------------------------------------------------
// Input-channel scheduler for the mpmc11 memory controller.
//
// The block arbitrates among NCH first-word-fall-through command FIFOs. It
// pops the winning head command and holds it in a register. The register is
// offered to the controller state machine as fifo_out/fifo_v and stays frozen
// while the state machine executes it. A fixed high-priority channel normally
// wins. A starvation counter periodically forces round-robin service of the
// remaining channels.
//
// Parameters
//   NCH        number of request channels (2..16)
//   HIPRI_CH   index of the high-priority channel
//   STARVE_LIM consecutive high-priority grants allowed while others wait
//   CMD_W      width of one fta command word
//
// Ports
//   clk          controller clock
//   rst          synchronous active-high reset
//   ch_v         per-channel FIFO non-empty (head valid)
//   ch_req       concatenated FIFO head commands; channel c at [c*CMD_W +: CMD_W]
//   ch_rd        one-hot FIFO pop strobe (combinational, grant cycle only)
//   select_next  controller state machine is in IDLE
//   fifo_out     held command
//   fifo_v       fifo_out is valid and not yet accepted
//   sel_ch       channel index of the held command (zero-extended)
//   hold_busy    a command is captured or being executed
// ---------------------------------------------------------------------------
module mpmc11_chan_sched_fta #(
  parameter int NCH        = 8,
  parameter int HIPRI_CH   = 0,
  parameter int STARVE_LIM = 16,
  parameter int CMD_W      = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ch_v,
  input  logic [NCH*CMD_W-1:0] ch_req,
  output logic [NCH-1:0]     ch_rd,
  input  logic               select_next,
  output logic [CMD_W-1:0]   fifo_out,
  output logic               fifo_v,
  output logic [3:0]         sel_ch,
  output logic               hold_busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] HI_BIT = NCH'(1) << HIPRI_CH;
  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_OFFER = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CMD_W-1:0]   fifo_out_q;
  logic               fifo_v_q;
  logic [3:0]         sel_ch_q;
  logic [3:0]         rr_ptr_q;
  logic [7:0]         starve_q;

  logic [CMD_W-1:0]   req_arr [NCH];
  logic [NCH-1:0]     others;
  logic               hi_win;
  logic               rr_found;
  logic [3:0]         rr_win;
  logic [3:0]         win;
  logic               grant;
  logic [CMD_W-1:0]   fifo_out_d;
  logic [3:0]         rr_ptr_d;
  logic [7:0]         starve_d;

  // Unpack the flat request bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign req_arr[gi] = ch_req[gi*CMD_W +: CMD_W];
    end
  endgenerate

  assign others = ch_v & ~HI_BIT;

  // The high-priority channel wins unless it has used up its starvation
  // allowance while someone else is waiting.
  assign hi_win = ch_v[HIPRI_CH] && ((starve_q < LIM) || (others == '0));

  // Round-robin search over the non-high-priority channels, starting just
  // after the last round-robin winner.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_win   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(rr_ptr_q) + i) % NCH;
      if (!rr_found && others[idx[PW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = 4'(idx);
      end
    end
  end

  assign win = hi_win ? 4'(HIPRI_CH) : rr_win;

  // EXEC with select_next high behaves like ARB, so back-to-back commands
  // are granted with no idle cycle in between.
  assign grant = !rst && select_next && (|ch_v) && (state_q != ST_OFFER);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_rd
      assign ch_rd[gi] = grant && (win == 4'(gi));
    end
  endgenerate

  assign fifo_out_d = req_arr[win[PW-1:0]];

  // Pointer and starvation bookkeeping for a grant in this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    starve_d = starve_q;
    if (hi_win) begin
      if (others != '0)
        starve_d = (starve_q >= LIM) ? LIM : starve_q + 8'd1;
    end else begin
      rr_ptr_d = rr_win;
      starve_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      fifo_out_q <= '0;
      fifo_v_q   <= 1'b0;
      sel_ch_q   <= '0;
      rr_ptr_q   <= 4'(NCH-1);
      starve_q   <= '0;
    end else begin
      case (state_q)
        ST_ARB, ST_EXEC: begin
          if (grant) begin
            fifo_out_q <= fifo_out_d;
            sel_ch_q   <= win;
            fifo_v_q   <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            starve_q   <= starve_d;
            state_q    <= ST_OFFER;
          end else if (state_q == ST_EXEC && select_next) begin
            // Controller is back in IDLE but nothing is waiting.
            state_q <= ST_ARB;
          end
        end
        ST_OFFER: begin
          // select_next low means the controller left IDLE with this command.
          if (!select_next) begin
            fifo_v_q <= 1'b0;
            state_q  <= ST_EXEC;
          end
        end
        default: begin
          state_q  <= ST_ARB;
          fifo_v_q <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_out  = fifo_out_q;
  assign fifo_v    = fifo_v_q;
  assign sel_ch    = sel_ch_q;
  assign hold_busy = (state_q != ST_ARB);

endmodule
